// File: rtl/crc_check.sv
// Receive-side CRC-8 checker. Captures a {data, crc} frame, divides the
// whole frame by the generator one bit per cycle, and reports whether the
// remainder is zero. Also keeps saturating frame/error/drop counters.
module crc_check #(
    parameter int                    LENGTH_DATA = 48,
    parameter int                    LENGTH_GEN  = 9,
    parameter logic [LENGTH_GEN-1:0] POLY        = 9'h131,
    parameter int                    CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LENGTH_DATA+LENGTH_GEN-2:0] frame_in,
    input  logic                          frame_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          crc_ok,
    output logic [LENGTH_DATA-1:0]        data_out,
    output logic [LENGTH_GEN-2:0]         rx_crc,
    output logic [LENGTH_GEN-2:0]         calc_rem,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int REM_W = LENGTH_GEN - 1;
    localparam int FW    = LENGTH_DATA + REM_W;
    localparam int IDX_W = $clog2(FW);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(FW - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REM_W-1:0] POLY_LO = POLY[REM_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        REPORT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [FW-1:0]     frame_reg;
    logic [REM_W-1:0]  rem;
    logic [IDX_W-1:0]  idx;

    // State register; reset returns the checker to IDLE immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one load cycle, FW shift cycles, one report cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (frame_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (idx == '0) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame capture and bit-serial long division of the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg <= '0;
            rem       <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        frame_reg <= frame_in;
                    end
                end
                LOAD: begin
                    rem <= '0;
                    idx <= IDX_TOP;
                end
                SHIFT: begin
                    rem <= {rem[REM_W-2:0], frame_reg[idx]} ^ (rem[REM_W-1] ? POLY_LO : '0);
                    if (idx != '0) begin
                        idx <= idx - IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers and statistics; results only move in REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            data_out  <= '0;
            rx_crc    <= '0;
            calc_rem  <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state == REPORT) begin
                done     <= 1'b1;
                crc_ok   <= (rem == '0);
                calc_rem <= rem;
                data_out <= frame_reg[FW-1:REM_W];
                rx_crc   <= frame_reg[REM_W-1:0];
                if (frame_cnt != '1) begin
                    frame_cnt <= frame_cnt + CNT_ONE;
                end
                if ((rem != '0) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
            if (frame_valid && busy && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_crc_check.sv
// Scoreboard bench for crc_check: expected results are queued when a frame
// is accepted and compared when done pulses. A second instance with 3-bit
// counters shares the inputs so counter saturation is reached quickly.
module tb_crc_check;

    localparam logic [8:0] POLY = 9'h131;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] frame_in;
    logic        frame_valid;

    logic        busy, done, crc_ok;
    logic [47:0] data_out;
    logic [7:0]  rx_crc, calc_rem;
    logic [15:0] frame_cnt, err_cnt, drop_cnt;

    logic        busy_s, done_s, crc_ok_s;
    logic [47:0] data_out_s;
    logic [7:0]  rx_crc_s, calc_rem_s;
    logic [2:0]  frame_cnt_s, err_cnt_s, drop_cnt_s;

    crc_check u_dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .busy(busy), .done(done), .crc_ok(crc_ok), .data_out(data_out),
        .rx_crc(rx_crc), .calc_rem(calc_rem), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    crc_check #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .busy(busy_s), .done(done_s), .crc_ok(crc_ok_s), .data_out(data_out_s),
        .rx_crc(rx_crc_s), .calc_rem(calc_rem_s), .frame_cnt(frame_cnt_s),
        .err_cnt(err_cnt_s), .drop_cnt(drop_cnt_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] data;
        logic [7:0]  crc;
        logic [7:0]  rem;
        logic        ok;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   last_accept = -1000;
    int   exp_frames = 0;
    int   exp_errs = 0;
    int   exp_drops = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // True polynomial long division of the frame by the generator.
    function automatic logic [7:0] refRem(input logic [55:0] f);
        logic [63:0] w;
        w = {8'h00, f};
        for (int i = 55; i >= 8; i--) begin
            if (w[i]) w = w ^ (64'(POLY) << (i - 8));
        end
        return w[7:0];
    endfunction

    function automatic logic [55:0] goodFrame(input logic [47:0] d);
        return {d, refRem({d, 8'h00})};
    endfunction

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame_valid strobe; caller is positioned 1 time unit after an edge.
    task automatic applyStimulus(input logic [55:0] f);
        exp_t e;
        frame_in    = f;
        frame_valid = 1'b1;
        if (cyc >= last_accept + 59) begin
            e.data     = f[55:8];
            e.crc      = f[7:0];
            e.rem      = refRem(f);
            e.ok       = (e.rem == 8'h00);
            e.done_cyc = cyc + 59;
            sb.push_back(e);
            last_accept = cyc;
        end else begin
            exp_drops++;
        end
        waitCycles(1);
        frame_valid = 1'b0;
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            waitCycles(1);
            t++;
        end
        if (sb.size() != 0) begin
            checkOutput("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic checkAllZero();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_crc_ok", 64'(crc_ok), 64'd0);
        checkOutput("rst_data_out", 64'(data_out), 64'd0);
        checkOutput("rst_rx_crc", 64'(rx_crc), 64'd0);
        checkOutput("rst_calc_rem", 64'(calc_rem), 64'd0);
        checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        checkOutput("rst_sat_frame_cnt", 64'(frame_cnt_s), 64'd0);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("done_unexpected", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                exp_frames++;
                if (!e.ok) exp_errs++;
                checkOutput("latency", 64'(cyc), 64'(e.done_cyc));
                checkOutput("crc_ok", 64'(crc_ok), 64'(e.ok));
                checkOutput("calc_rem", 64'(calc_rem), 64'(e.rem));
                checkOutput("data_out", 64'(data_out), 64'(e.data));
                checkOutput("rx_crc", 64'(rx_crc), 64'(e.crc));
                checkOutput("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
                checkOutput("err_cnt", 64'(err_cnt), 64'(exp_errs));
                checkOutput("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
                checkOutput("sat_done", 64'(done_s), 64'd1);
                checkOutput("sat_frame_cnt", 64'(frame_cnt_s), 64'(sat7(exp_frames)));
                checkOutput("sat_err_cnt", 64'(err_cnt_s), 64'(sat7(exp_errs)));
                checkOutput("sat_drop_cnt", 64'(drop_cnt_s), 64'(sat7(exp_drops)));
            end
        end
    end

    initial begin
        int n0;
        int errs_before;
        logic [47:0] d;

        rst         = 1'b1;
        frame_valid = 1'b0;
        frame_in    = '0;
        waitCycles(3);
        checkAllZero();
        rst = 1'b0;
        waitCycles(2);

        // Known-good frames and a single-bit error.
        applyStimulus(56'h0);
        waitDone();
        applyStimulus(56'h00000000000131);
        waitDone();
        applyStimulus(56'h00000000000130);
        waitDone();
        checkOutput("err_frame_rem", 64'(calc_rem), 64'h01);
        checkOutput("held_crc_ok", 64'(crc_ok), 64'd0);

        // Strobe during a check is dropped; strobe in the done cycle is accepted.
        waitCycles(2);
        n0 = cyc;
        applyStimulus(goodFrame(48'h123456789ABC));
        waitCycles(9);
        checkOutput("busy_mid", 64'(busy), 64'd1);
        applyStimulus(goodFrame(48'hFFFF00000000));
        waitCycles(n0 + 59 - cyc);
        checkOutput("done_at_accept", 64'(done), 64'd1);
        applyStimulus(goodFrame(48'hA5A5A5A5A5A5));
        waitDone();
        checkOutput("drop_after", 64'(drop_cnt), 64'd1);

        // Reset in the middle of SHIFT aborts everything.
        waitCycles(2);
        applyStimulus(56'h0000000000FF31);
        waitCycles(31);
        rst = 1'b1;
        waitCycles(1);
        checkAllZero();
        rst = 1'b0;
        sb.delete();
        last_accept = -1000;
        exp_frames  = 0;
        exp_errs    = 0;
        exp_drops   = 0;
        waitCycles(1);
        applyStimulus(goodFrame(48'h0000DEADBEEF));
        waitDone();

        // Random good frames; error count must stay put.
        errs_before = exp_errs;
        for (int i = 0; i < 1000; i++) begin
            d = {16'($urandom), 32'($urandom)};
            applyStimulus(goodFrame(d));
            waitDone();
        end
        checkOutput("err_cnt_random", 64'(err_cnt), 64'(errs_before));
        checkOutput("sat_frame_hold", 64'(frame_cnt_s), 64'd7);

        waitCycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
